// File: rtl/sipo_seq_ctrl.sv
// sipo_seq_ctrl
// Sequencing controller for a serial-in/parallel-out register path.
// Serial bits arrive over a valid/ready handshake and are counted into a
// frame. A completed frame becomes a parallel word on a valid/ready output.
// One finished word is held in the output register while the next frame
// shifts in. If a second frame completes before the first is consumed, it
// waits in the shift register and serial input is stalled.
//
// Parameters:
//   WIDTH     data bits per frame (2..64)
//   MSB_FIRST 1: first accepted bit lands in m_data[WIDTH-1]; 0: in m_data[0]
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   s_data    serial data bit
//   s_valid   s_data is valid
//   s_ready   a bit can be accepted this cycle (low in FULL and during rst)
//   s_clear   abort the partial/pending frame; output register untouched
//   m_data    completed parallel word
//   m_valid   m_data holds an unconsumed word
//   m_ready   consumer accepts m_data
//   m_perr    parity error flag for the word on m_data
//   busy      a frame is partially shifted or pending
//   bit_cnt   bits accepted in the current frame
//   word_cnt  words handed off, wraps at 16 bits
//
// Build option: define SIPO_CTRL_PARITY_EN to append one even-parity bit
// to every frame (WIDTH+1 bits). Without it m_perr is always 0.

module sipo_seq_ctrl #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic                         s_clear,
  output logic [WIDTH-1:0]             m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_perr,
  output logic                         busy,
  output logic [$clog2(WIDTH+2)-1:0]   bit_cnt,
  output logic [15:0]                  word_cnt
);

  localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef SIPO_CTRL_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t               state_r;
  logic [WIDTH-1:0]     shift_r;
  logic [CNT_W-1:0]     bit_cnt_r;
  logic [WIDTH-1:0]     m_data_r;
  logic                 m_valid_r;
  logic                 m_perr_r;
  logic [15:0]          word_cnt_r;
`ifdef SIPO_CTRL_PARITY_EN
  logic                 par_r;      // received parity bit of the pending frame
  logic                 data_bit_s;
`endif

  logic                 s_ready_s;
  logic                 accept_s;
  logic                 handoff_s;
  logic                 last_bit_s;
  logic [WIDTH-1:0]     shift_next_s;
  logic [WIDTH-1:0]     word_done_s;
  logic                 perr_done_s;
  logic                 pend_perr_s;

  // Even-parity check: 1 when data plus parity bit have odd weight.
  function automatic logic even_par_err(input logic [WIDTH-1:0] w, input logic p);
    return (^w) ^ p;
  endfunction

  assign s_ready_s  = (state_r != ST_FULL) && !rst;
  assign accept_s   = s_valid && s_ready_s;
  assign handoff_s  = m_valid_r && m_ready;
  assign last_bit_s = (bit_cnt_r == LAST_IDX);

  // Shift direction decides which end of the word the first bit ends up in.
  always_comb begin
    shift_next_s = shift_r;
    if (MSB_FIRST) begin
      shift_next_s = {shift_r[WIDTH-2:0], s_data};
    end else begin
      shift_next_s = {s_data, shift_r[WIDTH-1:1]};
    end
  end

  // Word and parity flag produced by the final bit of a frame.
`ifdef SIPO_CTRL_PARITY_EN
  assign data_bit_s  = (bit_cnt_r < CNT_W'(WIDTH));
  assign word_done_s = shift_r;                      // last bit is parity, not data
  assign perr_done_s = even_par_err(shift_r, s_data);
  assign pend_perr_s = even_par_err(shift_r, par_r);
`else
  assign word_done_s = shift_next_s;
  assign perr_done_s = 1'b0;
  assign pend_perr_s = 1'b0;
`endif

  // Frame sequencing, output register and handoff counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      shift_r    <= '0;
      bit_cnt_r  <= '0;
      m_data_r   <= '0;
      m_valid_r  <= 1'b0;
      m_perr_r   <= 1'b0;
      word_cnt_r <= 16'd0;
`ifdef SIPO_CTRL_PARITY_EN
      par_r      <= 1'b0;
`endif
    end else begin
      // A handoff empties the output register unless a new word loads below.
      if (handoff_s) begin
        m_valid_r  <= 1'b0;
        word_cnt_r <= word_cnt_r + 16'd1;
      end

      case (state_r)
        ST_IDLE, ST_SHIFT: begin
          if (s_clear) begin
            shift_r   <= '0;
            bit_cnt_r <= '0;
            state_r   <= ST_IDLE;
`ifdef SIPO_CTRL_PARITY_EN
            par_r     <= 1'b0;
`endif
          end else if (accept_s) begin
`ifdef SIPO_CTRL_PARITY_EN
            if (data_bit_s) begin
              shift_r <= shift_next_s;
            end else begin
              par_r <= s_data;
            end
`else
            shift_r <= shift_next_s;
`endif
            if (last_bit_s) begin
              if (!m_valid_r || handoff_s) begin
                // Output register free this edge: publish the word directly.
                m_data_r  <= word_done_s;
                m_perr_r  <= perr_done_s;
                m_valid_r <= 1'b1;
                shift_r   <= '0;
                bit_cnt_r <= '0;
                state_r   <= ST_IDLE;
              end else begin
                bit_cnt_r <= FULL_CNT;
                state_r   <= ST_FULL;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              state_r   <= ST_SHIFT;
            end
          end
        end

        ST_FULL: begin
          if (s_clear) begin
            // Pending word is discarded; the output register keeps its word.
            shift_r   <= '0;
            bit_cnt_r <= '0;
            state_r   <= ST_IDLE;
`ifdef SIPO_CTRL_PARITY_EN
            par_r     <= 1'b0;
`endif
          end else if (handoff_s) begin
            m_data_r  <= shift_r;
            m_perr_r  <= pend_perr_s;
            m_valid_r <= 1'b1;
            shift_r   <= '0;
            bit_cnt_r <= '0;
            state_r   <= ST_IDLE;
          end
        end

        default: begin
          shift_r   <= '0;
          bit_cnt_r <= '0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready  = s_ready_s;
  assign busy     = (state_r != ST_IDLE);
  assign bit_cnt  = bit_cnt_r;
  assign m_data   = m_data_r;
  assign m_valid  = m_valid_r;
  assign m_perr   = m_perr_r;
  assign word_cnt = word_cnt_r;

endmodule

// File: doc/sipo_seq_ctrl.md
# sipo_seq_ctrl

Sequencing controller for the serial-in/parallel-out register path. It accepts a serial bit stream through a valid/ready handshake and counts bits into a WIDTH-bit frame. It presents each completed word on a parallel valid/ready output and holds one finished word while the next frame shifts in. It sits between the serial source driven by the bench/control domain and any consumer of parallel words.

## Interface
Parameters:
- WIDTH, 8, data bits per frame; legal range 2..64.
- MSB_FIRST, 1, 1 = first accepted bit lands in m_data[WIDTH-1]; 0 = first bit lands in m_data[0].

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_data  input  1  serial data bit.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  controller can accept a bit this cycle.
- s_clear  input  1  abort the partial frame.
- m_data  output  WIDTH  completed parallel word.
- m_valid  output  1  m_data holds an unconsumed word.
- m_ready  input  1  consumer accepts m_data.
- m_perr  output  1  parity error flag for the word on m_data.
- busy  output  1  a frame is partially shifted or pending.
- bit_cnt  output  $clog2(WIDTH+2)  bits accepted in the current frame.
- word_cnt  output  16  count of words handed off.

## Operation
- Bit accept: s_valid && s_ready at the clk edge. Word handoff: m_valid && m_ready at the clk edge.
- The shift register and the output register are separate. The output register holds one word.
- FSM states:
  - IDLE: bit_cnt=0; s_ready=1. An accepted bit moves the FSM to SHIFT with bit_cnt=1.
  - SHIFT: s_ready=1; each accepted bit increments bit_cnt. On acceptance of the final frame bit:
    - If the output register is empty, or a handoff occurs in the same cycle, the word loads into the output register, m_valid becomes 1 and the FSM goes to IDLE.
    - Otherwise the FSM goes to FULL.
  - FULL: s_ready=0. The completed word waits in the shift register. On a handoff, the word moves into the output register, m_valid stays 1 and the FSM goes to IDLE.
- s_clear has priority over a bit accepted in the same cycle. It zeroes the shift register and bit_cnt and forces IDLE. In FULL it discards the pending word. It never touches the output register, m_valid or m_perr.
- busy = (state != IDLE).
- word_cnt increments on each handoff and wraps from 0xFFFF to 0x0000.
- s_ready is combinational from state only. It never depends on s_valid.

## Timing
- Reset (rst high at an edge) sets:
  - state IDLE, shift register 0, bit_cnt 0, word_cnt 0, m_data 0, m_valid 0, m_perr 0.
  - s_ready is forced 0 while rst is high.
- Reset mid-frame or mid-hold discards all data with no handoff.
- Latency: m_valid rises in the cycle after the edge that accepts the final frame bit.
- Throughput: one bit per cycle sustained when m_ready is held high. No bubble between frames.
- m_data and m_perr are stable while m_valid=1 && m_ready=0.
- Simultaneous final-bit accept and handoff: the new word replaces the old one on the same edge and m_valid stays 1.

## Configuration
- Macro SIPO_CTRL_PARITY_EN.
- Defined:
  - A frame is WIDTH+1 bits: the data bits followed by one even-parity bit.
  - bit_cnt counts to WIDTH+1.
  - m_perr = 1 when the XOR of the data bits and the parity bit is 1. It loads together with m_data.
  - The parity bit is not stored in m_data.
- Undefined:
  - A frame is WIDTH bits.
  - m_perr is tied to 0.

## Test plan
WIDTH=8, MSB_FIRST=1, macro undefined unless stated.
- Reset, then stream 1,0,1,0,0,1,0,1 with m_ready=1 -> m_data=0xA5 and m_valid=1 one cycle after the 8th accept; word_cnt=1.
- m_ready=0, stream 0xA5 then 0x3C -> s_ready=0 after the 16th bit, busy=1. Raise m_ready -> 0xA5 is handed off, then 0x3C appears on the next cycle with no gap.
- Shift 5 bits, assert s_clear with s_valid=1 -> bit_cnt=0 and the bit is dropped. The next 8 bits 0xFF give m_data=0xFF.
- MSB_FIRST=0, stream 1,0,0,0,0,0,0,0 -> m_data=0x01.
- With SIPO_CTRL_PARITY_EN, stream 0xA5 plus parity 0 -> m_perr=0. Stream 0xA5 plus parity 1 -> m_perr=1.
- Assert rst after 4 bits, then stream 0x5A -> m_data=0x5A, word_cnt=1, no stale bits.
